// File: rtl/spi_ram_burst.sv
// SPI-slave backed memory: decodes 2-bit command words into address/data writes
// and burst reads, holding tx_valid for a programmable window per read.
module spi_ram_burst #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned TX_HOLD  = 8,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              rd_overrun
);

  localparam int unsigned MEM_DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W     = $clog2(TX_HOLD + 1);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t              state;
  logic [CNT_W-1:0]    hold_cnt;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  logic [1:0]          cmd;
  logic [DATA_W-1:0]   payload;
  logic [ADDR_W-1:0]   addr_arg;
  logic                rd_ready;

  assign cmd      = din[DATA_W+1:DATA_W];
  assign payload  = din[DATA_W-1:0];
  assign addr_arg = ADDR_W'(payload);
  // The final hold cycle counts as idle, so a read landing exactly at window end chains on.
  assign rd_ready = (state == IDLE) || (hold_cnt == '0);

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rx_valid && (cmd == CMD_WR_DATA)) begin
      mem[wr_addr] <= payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      wr_addr    <= '0;
      rd_addr    <= '0;
      dout       <= '0;
      tx_valid   <= 1'b0;
      rd_overrun <= 1'b0;
    end else begin
      rd_overrun <= 1'b0;

      if (state == HOLD) begin
        if (hold_cnt == '0) begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - CNT_W'(1);
        end
      end

      // An accepted read below overrides the window bookkeeping above.
      if (rx_valid) begin
        case (cmd)
          CMD_WR_ADDR: wr_addr <= addr_arg;
          CMD_WR_DATA: begin
            if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_W'(1);
          end
          CMD_RD_ADDR: rd_addr <= addr_arg;
          CMD_RD_DATA: begin
            if (rd_ready) begin
              dout     <= mem[rd_addr];
              hold_cnt <= CNT_W'(TX_HOLD - 1);
              state    <= HOLD;
              tx_valid <= 1'b1;
              if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_W'(1);
            end else begin
              rd_overrun <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Scoreboard bench for spi_ram_burst: an 8-cycle-hold instance for most scenarios
// and a 4-cycle-hold instance for the chained-read boundary.
module tb_spi_ram_burst;

  logic       clk = 1'b0;
  logic       rst;
  logic       rv8, rv4;
  logic [9:0] din8, din4;
  logic [7:0] dout8, dout4;
  logic       tv8, tv4, ov8, ov4;

  int total = 0;
  int bad   = 0;

  logic [7:0]  m [256];
  int unsigned mw = 0;
  int unsigned mr = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  e;
  logic [7:0]  saved;

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .TX_HOLD(8), .AUTO_INC(1)) dut8 (
    .clk(clk), .rst(rst), .rx_valid(rv8), .din(din8),
    .dout(dout8), .tx_valid(tv8), .rd_overrun(ov8)
  );

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .TX_HOLD(4), .AUTO_INC(1)) dut4 (
    .clk(clk), .rst(rst), .rx_valid(rv4), .din(din4),
    .dout(dout4), .tx_valid(tv4), .rd_overrun(ov4)
  );

  // Drive one command for one cycle starting at a negedge; updates the reference model.
  task automatic cmd8(input logic [1:0] c, input logic [7:0] p);
    rv8  = 1'b1;
    din8 = {c, p};
    @(negedge clk);
    rv8  = 1'b0;
    if (c == 2'b00) mw = 32'(p);
    else if (c == 2'b01) begin
      m[mw] = p;
      mw = (mw + 1) % 256;
    end else if (c == 2'b10) mr = 32'(p);
  endtask

  task automatic rd8(input bit accept);
    if (accept) begin
      exp_q.push_back(m[mr]);
      mr = (mr + 1) % 256;
    end
    cmd8(2'b11, 8'h00);
  endtask

  task automatic cmd4(input logic [1:0] c, input logic [7:0] p);
    rv4  = 1'b1;
    din4 = {c, p};
    @(negedge clk);
    rv4  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rv8 = 1'b0; din8 = '0;
    rv4 = 1'b0; din4 = '0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dout8 !== 8'h00) begin bad++; $display("FAIL reset_dout8: got %h want 00", dout8); end
    total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL reset_tv8: got %b want 0", tv8); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_ov8: got %b want 0", ov8); end
    total++; if (tv4 !== 1'b0) begin bad++; $display("FAIL reset_tv4: got %b want 0", tv4); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    cmd8(2'b00, 8'h10);
    cmd8(2'b01, 8'hA5);
    cmd8(2'b10, 8'h10);
    rd8(1'b1);
    e = exp_q.pop_front();
    total++; if (dout8 !== e) begin bad++; $display("FAIL basic_dout: got %h want %h", dout8, e); end
    for (int i = 0; i < 8; i++) begin
      total++; if (tv8 !== 1'b1) begin bad++; $display("FAIL basic_tv cycle %0d: got %b want 1", i, tv8); end
      total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL basic_ov cycle %0d: got %b want 0", i, ov8); end
      @(negedge clk);
    end
    total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL basic_tv_end: got %b want 0", tv8); end
  endtask

  task automatic test_burst;
    cmd8(2'b00, 8'hFE);
    cmd8(2'b01, 8'h11);
    cmd8(2'b01, 8'h22);
    cmd8(2'b01, 8'h33);
    cmd8(2'b10, 8'hFE);
    for (int k = 0; k < 3; k++) begin
      rd8(1'b1);
      e = exp_q.pop_front();
      total++; if (dout8 !== e) begin bad++; $display("FAIL burst_dout %0d: got %h want %h", k, dout8, e); end
      for (int i = 0; i < 8; i++) @(negedge clk);
      total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL burst_tv_end %0d: got %b want 0", k, tv8); end
    end
  endtask

  task automatic test_overrun;
    cmd8(2'b10, 8'hFE);
    rd8(1'b1);
    e = exp_q.pop_front();
    saved = e;
    total++; if (dout8 !== e) begin bad++; $display("FAIL ovr_first_dout: got %h want %h", dout8, e); end
    @(negedge clk);
    @(negedge clk);
    rd8(1'b0);
    total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL ovr_pulse: got %b want 1", ov8); end
    total++; if (dout8 !== saved) begin bad++; $display("FAIL ovr_dout_kept: got %h want %h", dout8, saved); end
    @(negedge clk);
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL ovr_pulse_len: got %b want 0", ov8); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tv8 !== 1'b1) begin bad++; $display("FAIL ovr_tv cycle %0d: got %b want 1", i, tv8); end
      @(negedge clk);
    end
    total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL ovr_tv_end: got %b want 0", tv8); end
    rd8(1'b1);
    e = exp_q.pop_front();
    total++; if (dout8 !== e) begin bad++; $display("FAIL ovr_rdaddr_kept: got %h want %h", dout8, e); end
    for (int i = 0; i < 8; i++) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    cmd4(2'b00, 8'h20);
    cmd4(2'b01, 8'h5A);
    cmd4(2'b01, 8'hC3);
    cmd4(2'b10, 8'h20);
    exp_q.push_back(8'h5A);
    cmd4(2'b11, 8'h00);
    e = exp_q.pop_front();
    total++; if (dout4 !== e) begin bad++; $display("FAIL b2b_dout0: got %h want %h", dout4, e); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tv4 !== 1'b1) begin bad++; $display("FAIL b2b_tv0 cycle %0d: got %b want 1", i, tv4); end
      total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL b2b_ov0 cycle %0d: got %b want 0", i, ov4); end
      if (i < 3) @(negedge clk);
    end
    exp_q.push_back(8'hC3);
    cmd4(2'b11, 8'h00);
    e = exp_q.pop_front();
    total++; if (dout4 !== e) begin bad++; $display("FAIL b2b_dout1: got %h want %h", dout4, e); end
    for (int i = 0; i < 4; i++) begin
      total++; if (tv4 !== 1'b1) begin bad++; $display("FAIL b2b_tv1 cycle %0d: got %b want 1", i, tv4); end
      total++; if (ov4 !== 1'b0) begin bad++; $display("FAIL b2b_ov1 cycle %0d: got %b want 0", i, ov4); end
      @(negedge clk);
    end
    total++; if (tv4 !== 1'b0) begin bad++; $display("FAIL b2b_tv_end: got %b want 0", tv4); end
  endtask

  task automatic test_interleave;
    cmd8(2'b10, 8'h10);
    rd8(1'b1);
    e = exp_q.pop_front();
    saved = e;
    total++; if (dout8 !== e) begin bad++; $display("FAIL intl_dout: got %h want %h", dout8, e); end
    cmd8(2'b00, 8'h05);
    cmd8(2'b01, 8'h77);
    total++; if (dout8 !== saved) begin bad++; $display("FAIL intl_dout_kept: got %h want %h", dout8, saved); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL intl_ov: got %b want 0", ov8); end
    for (int i = 0; i < 6; i++) begin
      total++; if (tv8 !== 1'b1) begin bad++; $display("FAIL intl_tv cycle %0d: got %b want 1", i, tv8); end
      @(negedge clk);
    end
    total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL intl_tv_end: got %b want 0", tv8); end
    cmd8(2'b10, 8'h05);
    rd8(1'b1);
    e = exp_q.pop_front();
    total++; if (dout8 !== e) begin bad++; $display("FAIL intl_readback: got %h want %h", dout8, e); end
    for (int i = 0; i < 8; i++) @(negedge clk);
  endtask

  task automatic test_async_reset;
    cmd8(2'b10, 8'h10);
    rd8(1'b1);
    e = exp_q.pop_front();
    total++; if (dout8 !== e) begin bad++; $display("FAIL arst_pre_dout: got %h want %h", dout8, e); end
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL arst_tv: got %b want 0", tv8); end
    total++; if (dout8 !== 8'h00) begin bad++; $display("FAIL arst_dout: got %h want 00", dout8); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL arst_ov: got %b want 0", ov8); end
    @(negedge clk);
    rst = 1'b0;
    mw = 0;
    mr = 0;
    exp_q.delete();
    rd8(1'b1);
    e = exp_q.pop_front();
    total++; if (dout8 !== e) begin bad++; $display("FAIL arst_mem0: got %h want %h", dout8, e); end
    for (int i = 0; i < 8; i++) begin
      total++; if (tv8 !== 1'b1) begin bad++; $display("FAIL arst_tv_win cycle %0d: got %b want 1", i, tv8); end
      @(negedge clk);
    end
    total++; if (tv8 !== 1'b0) begin bad++; $display("FAIL arst_tv_end: got %b want 0", tv8); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_overrun();
    test_back_to_back();
    test_interleave();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
